// File: rtl/cl_frame_drain_if.sv
// Write-request channel from cl_frame_drain toward the host write path.
// master: drives the request (cl_frame_drain); slave: returns wr_ready.
interface cl_frame_drain_if #(
  parameter int CL     = 512,
  parameter int ADDR_W = 42
) ();
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [CL-1:0]     wr_data;
  logic              wr_sop;
  logic              wr_eop;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_sop, wr_eop,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_sop, wr_eop,
    output wr_ready
  );
endinterface

// File: rtl/cl_frame_drain.sv
// cl_frame_drain: reads one buffered frame out of the post-AFU CL buffer and
// issues it as addressed cache-line write requests. A 2-entry queue absorbs
// the buffer's one-cycle read latency so write backpressure never drops data.
// Optional build macro CL_FRAME_DRAIN_STATS_EN enables the frame_cnt counter;
// when undefined, frame_cnt is tied to zero.
module cl_frame_drain #(
  parameter int CL     = 512,
  parameter int W_LEN  = 10,
  parameter int ADDR_W = 42
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ff_rd_ready,
  input  logic [W_LEN-1:0]  sb_len,
  output logic              ff_rdreq,
  input  logic [CL-1:0]     ff_q,
  output logic              ff_rd_finish,
  input  logic [ADDR_W-1:0] wr_base,
  cl_frame_drain_if.master  wr,
  output logic              busy,
  output logic [15:0]       frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_DRAIN, S_FIN, S_HOLD
  } state_t;

  state_t            state_q, state_d;
  logic [W_LEN-1:0]  len_q, issued_q, emitted_q;
  logic [ADDR_W-1:0] base_q;
  logic              inflight_q;
  logic [CL-1:0]     mem_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  logic              push, pop, credit_ok;
  logic [2:0]        occ, lim;

  assign push        = inflight_q;
  assign wr.wr_valid = (count_q != 2'd0);
  assign pop         = wr.wr_valid & wr.wr_ready;
  assign occ         = {1'b0, count_q} + {2'b00, inflight_q};
  assign lim         = 3'd2 + {2'b00, pop};
  assign credit_ok   = (occ < lim);

  assign wr.wr_data  = mem_q[rd_ptr_q];
  assign wr.wr_addr  = base_q + ADDR_W'(emitted_q);
  assign wr.wr_sop   = wr.wr_valid && (emitted_q == '0);
  assign wr.wr_eop   = wr.wr_valid && (emitted_q == len_q - W_LEN'(1));
  assign busy        = (state_q != S_IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, read request and finish pulse.
  always_comb begin
    state_d      = state_q;
    ff_rdreq     = 1'b0;
    ff_rd_finish = 1'b0;
    unique case (state_q)
      S_IDLE:  if (ff_rd_ready) state_d = S_LOAD;
      S_LOAD:  state_d = (sb_len == '0) ? S_FIN : S_READ;
      S_READ: begin
        if (credit_ok) begin
          ff_rdreq = 1'b1;
          if (issued_q == len_q - W_LEN'(1)) state_d = S_DRAIN;
        end
      end
      // Leave as soon as the queue empties on this edge, so the finish
      // pulse lands the cycle right after the last line is accepted.
      S_DRAIN: begin
        if (!inflight_q && (count_q == 2'd0 || (count_q == 2'd1 && pop)))
          state_d = S_FIN;
      end
      S_FIN: begin
        ff_rd_finish = 1'b1;
        state_d      = S_HOLD;
      end
      S_HOLD:  if (!ff_rd_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Frame bookkeeping, read-return tracking and the 2-entry output queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      base_q     <= '0;
      issued_q   <= '0;
      emitted_q  <= '0;
      inflight_q <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= '0;
    end else begin
      if (state_q == S_LOAD) begin
        len_q     <= sb_len;
        base_q    <= wr_base;
        issued_q  <= '0;
        emitted_q <= '0;
      end
      if (ff_rdreq) issued_q <= issued_q + W_LEN'(1);
      inflight_q <= ff_rdreq;
      if (push) begin
        mem_q[wr_ptr_q] <= ff_q;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q  <= ~rd_ptr_q;
        emitted_q <= emitted_q + W_LEN'(1);
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef CL_FRAME_DRAIN_STATS_EN
  logic [15:0] frame_cnt_q;

  // Completed-frame counter; wraps at 2^16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                frame_cnt_q <= '0;
    else if (state_q == S_FIN) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_cl_frame_drain.sv
// Self-checking bench for cl_frame_drain: table of frame scenarios, a
// behavioural FIFO/scoreboard model, plus a mid-frame asynchronous reset.
module tb_cl_frame_drain;

  localparam int CL     = 512;
  localparam int W_LEN  = 10;
  localparam int ADDR_W = 42;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ff_rd_ready;
  logic [W_LEN-1:0]  sb_len;
  logic              ff_rdreq;
  logic [CL-1:0]     ff_q = '0;
  logic              ff_rd_finish;
  logic [ADDR_W-1:0] wr_base;
  logic              busy;
  logic [15:0]       frame_cnt;

  cl_frame_drain_if #(.CL(CL), .ADDR_W(ADDR_W)) wr ();

  cl_frame_drain #(.CL(CL), .W_LEN(W_LEN), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ff_rd_ready  (ff_rd_ready),
    .sb_len       (sb_len),
    .ff_rdreq     (ff_rdreq),
    .ff_q         (ff_q),
    .ff_rd_finish (ff_rd_finish),
    .wr_base      (wr_base),
    .wr           (wr),
    .busy         (busy),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int cyc0, rdreq_cnt, acc_cnt, fin_cnt, first_valid, fin_delta, max_out;
  int exp_len, fifo_idx, exp_frames;
  logic [ADDR_W-1:0] exp_base;
  logic [CL-1:0]     src [$];
  bit                mon_en  = 1'b0;
  bit                rd_seen = 1'b0;

  task automatic chk(input string nm, input logic [CL-1:0] got, input logic [CL-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [CL-1:0] rand_cl();
    logic [CL-1:0] r;
    for (int i = 0; i < CL / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [15:0] exp_fc();
`ifdef CL_FRAME_DRAIN_STATS_EN
    return 16'(exp_frames);
`else
    return 16'd0;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream buffer model: data appears on ff_q the cycle after a read request;
  // otherwise ff_q carries junk so a spurious push would be caught.
  always @(posedge clk) begin
    if (rd_seen && fifo_idx < src.size()) begin
      ff_q <= src[fifo_idx];
      fifo_idx = fifo_idx + 1;
    end else begin
      ff_q <= rand_cl();
    end
  end

  // Scoreboard: every cycle with wr_valid high must present the next expected line.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    rd_seen = ff_rdreq;
    if (mon_en && rst_n) begin
      if (ff_rdreq) rdreq_cnt++;
      if (wr.wr_valid) begin
        if (first_valid < 0) first_valid = cyc - cyc0;
        if (acc_cnt < exp_len) begin
          ea = exp_base + ADDR_W'(acc_cnt);
          chk("wr_addr", wr.wr_addr, ea);
          chk("wr_data", wr.wr_data, src[acc_cnt]);
          chk("wr_sop",  wr.wr_sop,  acc_cnt == 0);
          chk("wr_eop",  wr.wr_eop,  acc_cnt == exp_len - 1);
        end else begin
          chk("extra_valid", wr.wr_valid, 1'b0);
        end
        if (wr.wr_ready) acc_cnt++;
      end
      if (rdreq_cnt - acc_cnt > max_out) max_out = rdreq_cnt - acc_cnt;
      if (ff_rd_finish) begin
        fin_cnt++;
        fin_delta = cyc - cyc0;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rdreq"},  ff_rdreq,     1'b0);
    chk({tag, "_finish"}, ff_rd_finish, 1'b0);
    chk({tag, "_valid"},  wr.wr_valid,  1'b0);
    chk({tag, "_sop"},    wr.wr_sop,    1'b0);
    chk({tag, "_eop"},    wr.wr_eop,    1'b0);
    chk({tag, "_addr"},   wr.wr_addr,   '0);
    chk({tag, "_data"},   wr.wr_data,   '0);
    chk({tag, "_busy"},   busy,         1'b0);
    chk({tag, "_fcnt"},   frame_cnt,    16'd0);
  endtask

  task automatic start_frame(input int len, input logic [ADDR_W-1:0] base);
    src.delete();
    for (int i = 0; i < len; i++) src.push_back(rand_cl());
    fifo_idx = 0; rdreq_cnt = 0; acc_cnt = 0; fin_cnt = 0;
    first_valid = -1; fin_delta = -1; max_out = 0;
    exp_len = len; exp_base = base;
    @(posedge clk); #1;
    ff_rd_ready = 1'b1;
    sb_len      = W_LEN'(len);
    wr_base     = base;
    cyc0        = cyc;
    mon_en      = 1'b1;
  endtask

  // efv/efin: expected first-valid and finish cycle offsets from raising
  // ff_rd_ready; -2 means not checked, -1 means must never happen.
  task automatic run_frame(input int len, input logic [ADDR_W-1:0] base,
                           input int pct, input int efv, input int efin);
    int n;
    int budget;
    budget = len * 30 + 60;
    start_frame(len, base);
    n = 0;
    while (fin_cnt == 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (cyc == cyc0 + 2) begin
        sb_len  = W_LEN'($urandom());
        wr_base = {$urandom(), $urandom()};
      end
      wr.wr_ready = ($urandom_range(0, 99) < pct);
    end
    chk("finish_timeout", n < budget, 1'b1);
    chk("rdreq_count", rdreq_cnt, len);
    chk("accept_count", acc_cnt, len);
    chk("max_outstanding_le2", max_out <= 2, 1'b1);
    if (efv != -2)  chk("first_valid_lat", first_valid, efv);
    if (efin != -2) chk("finish_lat", fin_delta, efin);
    exp_frames++;
    wr.wr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("hold_busy", busy, 1'b1);
    chk("single_finish", fin_cnt, 1);
    chk("hold_no_rdreq", rdreq_cnt, len);
    chk("frame_cnt", frame_cnt, exp_fc());
    ff_rd_ready = 1'b0;
    @(posedge clk); #1;
    chk("idle_after_drop", busy, 1'b0);
    mon_en = 1'b0;
  endtask

  typedef struct {
    int                len;
    logic [ADDR_W-1:0] base;
    int                pct;
    int                efv;
    int                efin;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    vecs[0] = '{len: 4,    base: 42'h100,           pct: 100, efv: 4,  efin: 8};
    vecs[1] = '{len: 1,    base: 42'h2000,          pct: 100, efv: 4,  efin: 5};
    vecs[2] = '{len: 0,    base: 42'h55,            pct: 100, efv: -1, efin: 2};
    vecs[3] = '{len: 64,   base: 42'h4000,          pct: 50,  efv: -2, efin: -2};
    vecs[4] = '{len: 4,    base: 42'h3FF_FFFF_FFFE, pct: 100, efv: 4,  efin: 8};
    vecs[5] = '{len: 20,   base: 42'h1234_5678,     pct: 75,  efv: -2, efin: -2};
    vecs[6] = '{len: 1023, base: 42'h80,            pct: 90,  efv: -2, efin: -2};

    rst_n = 1'b0; ff_rd_ready = 1'b0; sb_len = '0; wr_base = '0;
    wr.wr_ready = 1'b0; exp_frames = 0;
    #1;
    check_reset_vals("rst_init");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++)
      run_frame(vecs[i].len, vecs[i].base, vecs[i].pct, vecs[i].efv, vecs[i].efin);

    // Asynchronous reset after 3 of 8 lines accepted.
    wr.wr_ready = 1'b1;
    start_frame(8, 42'h300);
    n = 0;
    while (acc_cnt < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_reset_reach3", acc_cnt, 3);
    rst_n = 1'b0;
    ff_rd_ready = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    mon_en = 1'b0;
    chk("mid_reset_no_finish", fin_cnt, 0);
    exp_frames = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(5, 42'h700, 100, 4, 9);
    chk("frame_cnt_after_reset", frame_cnt, exp_fc());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule
